// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter. Bytes are popped in push order and
// handed to the transmitter with a one-cycle send_data strobe. Strobes are
// spaced so that one full frame can finish before the next byte is offered.
module uart_tx_fifo #(
    parameter int DEPTH        = 8,
    parameter int FRAME_CYCLES = 57292
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic [7:0]               tx_data,
    output logic                     send_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [7:0]      mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_s;
    logic [FW-1:0]   frame_cnt_r;
    logic [7:0]      tx_data_r;
    logic            send_data_r;
    logic            overflow_r;
    logic            full_r;
    logic            empty_r;
    logic            busy_r;
    logic            push_s;
    logic            drop_s;
    logic            pop_s;
    logic            frame_clr_s;
    logic            frame_inc_s;

    // Transmit sequencing: pop one byte, strobe it, then hold off for a frame.
    always_comb begin
        state_s     = state_r;
        pop_s       = 1'b0;
        frame_clr_s = 1'b0;
        frame_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_r) begin
                    pop_s   = 1'b1;
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                frame_clr_s = 1'b1;
                state_s     = ST_WAIT;
            end
            ST_WAIT: begin
                // Counter stops at its terminal value so it can never wrap.
                if (frame_cnt_r == FRAME_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    frame_inc_s = 1'b1;
                    state_s     = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Push admission and next occupancy; full is the registered flag, so a
    // pop in the same cycle never makes room for a push.
    always_comb begin
        push_s  = wr_en && !full_r;
        drop_s  = wr_en && full_r;
        count_s = count_r;
        if (push_s && !pop_s) begin
            count_s = count_r + CW'(1);
        end else if (!push_s && pop_s) begin
            count_s = count_r - CW'(1);
        end else begin
            count_s = count_r;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Storage array; contents are never observable until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Occupancy and its flag decodes, all updated together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            count_r <= count_s;
            full_r  <= (count_s == COUNT_FULL);
            empty_r <= (count_s == CW'(0));
            busy_r  <= (count_s != CW'(0)) || (state_s != ST_IDLE);
        end
    end

    // Frame spacing timer, cleared while the strobe is out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_r <= '0;
        end else if (frame_clr_s) begin
            frame_cnt_r <= '0;
        end else if (frame_inc_s) begin
            frame_cnt_r <= frame_cnt_r + FW'(1);
        end
    end

    // Transmit byte holds the last popped value; strobe is high while in SEND.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data_r   <= 8'h00;
            send_data_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (pop_s) begin
                tx_data_r <= mem_r[rd_ptr_r];
            end
            send_data_r <= (state_s == ST_SEND);
            overflow_r  <= drop_s;
        end
    end

    assign tx_data   = tx_data_r;
    assign send_data = send_data_r;
    assign overflow  = overflow_r;
    assign count     = count_r;
    assign full      = full_r;
    assign empty     = empty_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue-based timing model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 8;
    localparam int FC    = 20;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic [7:0]    tx_data;
    logic          send_data;
    logic          busy;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;

    uart_tx_fifo #(.DEPTH(DEPTH), .FRAME_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .tx_data(tx_data), .send_data(send_data), .busy(busy),
        .count(count), .full(full), .empty(empty), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    // Model: queue of pending bytes, edge index, earliest edge for the next pop.
    logic [7:0] q[$];
    logic [7:0] sent_log[$];
    int         t = 0;
    int         next_pop = 0;
    logic [7:0] m_tx = 8'h00;
    bit         m_send = 1'b0;
    bit         m_ovf = 1'b0;
    bit         m_frame = 1'b0;
    int         sends_seen = 0;
    int         ovf_seen = 0;
    int         peak_count = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        next_pop = 0;
        m_tx = 8'h00;
        m_send = 1'b0;
        m_ovf = 1'b0;
        m_frame = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_tx"},    32'(tx_data),   32'h00);
        check_eq({tag, "_send"},  32'(send_data), 32'd0);
        check_eq({tag, "_ovf"},   32'(overflow),  32'd0);
        check_eq({tag, "_empty"}, 32'(empty),     32'd1);
        check_eq({tag, "_full"},  32'(full),      32'd0);
        check_eq({tag, "_busy"},  32'(busy),      32'd0);
        check_eq({tag, "_count"}, 32'(count),     32'd0);
    endtask

    // One clock: drive inputs, advance model at the edge, compare at negedge.
    task automatic step(input bit we, input logic [7:0] d);
        bit pop_now;
        int pre_size;
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        pre_size = q.size();
        pop_now  = (pre_size != 0) && (t >= next_pop);
        m_send   = pop_now;
        if (pop_now) begin
            m_tx     = q.pop_front();
            next_pop = t + FC + 2;
        end
        m_ovf = we && (pre_size >= DEPTH);
        if (we && (pre_size < DEPTH)) q.push_back(d);
        m_frame = (t < next_pop - 1);
        t++;
        @(negedge clk);
        check_eq("count", 32'(count), 32'(q.size()));
        check_eq("full", 32'(full), 32'(q.size() == DEPTH));
        check_eq("empty", 32'(empty), 32'(q.size() == 0));
        check_eq("busy", 32'(busy), 32'((q.size() != 0) || m_frame));
        check_eq("send_data", 32'(send_data), 32'(m_send));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("tx_data", 32'(tx_data), 32'(m_tx));
        if (send_data) begin
            sends_seen++;
            sent_log.push_back(tx_data);
        end
        if (overflow) ovf_seen++;
        if (int'(count) > peak_count) peak_count = int'(count);
    endtask

    task automatic drain();
        for (int i = 0; i < (DEPTH + 3) * (FC + 2); i++) begin
            if (q.size() == 0 && t >= next_pop) break;
            step(1'b0, 8'h00);
        end
        step(1'b0, 8'h00);
    endtask

    // Asynchronous reset pulse from the middle of a low clock phase.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("rst_async");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int base;
        int pushed;
        rst = 1'b0;
        wr_en = 1'b0;
        wr_data = 8'h00;
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00);

        // Single byte into an empty idle FIFO.
        base = sends_seen;
        step(1'b1, 8'hA5);
        step(1'b0, 8'h00);
        check_eq("single_send", 32'(send_data), 32'd1);
        check_eq("single_tx", 32'(tx_data), 32'hA5);
        drain();
        check_eq("single_count", 32'(sends_seen - base), 32'd1);

        // Four-byte burst on consecutive cycles.
        base = sends_seen;
        peak_count = 0;
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i));
        drain();
        check_eq("burst_sends", 32'(sends_seen - base), 32'd4);
        check_eq("burst_peak", 32'(peak_count), 32'd3);
        for (int i = 0; i < 4; i++)
            check_eq("burst_order", 32'(sent_log[sent_log.size() - 4 + i]), 32'(i + 1));

        // Fill while a frame is in progress: DEPTH fit, two are dropped.
        base = ovf_seen;
        pushed = sends_seen;
        step(1'b1, 8'hE0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
        for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 8'(8'h10 + i));
        check_eq("ovf_full", 32'(full), 32'd1);
        step(1'b0, 8'h00);
        check_eq("ovf_pulses", 32'(ovf_seen - base), 32'd2);
        drain();
        check_eq("ovf_sends", 32'(sends_seen - pushed), 32'(DEPTH + 1));
        for (int i = 0; i < DEPTH; i++)
            check_eq("ovf_data", 32'(sent_log[sent_log.size() - DEPTH + i]), 32'(8'h10 + i));

        // Push on the pop edge with one byte queued.
        step(1'b1, 8'h55);
        step(1'b1, 8'h66);
        check_eq("simul_count", 32'(count), 32'd1);
        drain();
        check_eq("simul_order", 32'(sent_log[sent_log.size() - 1]), 32'h66);

        // Pointer wrap: 3*DEPTH incrementing bytes without drops.
        base = sends_seen;
        pushed = 0;
        for (int i = 0; i < 3 * DEPTH * (FC + 4) && pushed < 3 * DEPTH; i++) begin
            if (q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                step(1'b1, 8'(pushed));
                pushed++;
            end else begin
                step(1'b0, 8'h00);
            end
        end
        drain();
        check_eq("wrap_sends", 32'(sends_seen - base), 32'(3 * DEPTH));
        for (int i = 0; i < 3 * DEPTH; i++)
            check_eq("wrap_data", 32'(sent_log[sent_log.size() - 3 * DEPTH + i]), 32'(i));

        // Random traffic, including occasional drops.
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 9) == 0, 8'($urandom));
        drain();

        // Reset while waiting with three bytes queued.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i));
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
        check_eq("pre_rst_count", 32'(count), 32'd3);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        do_reset();
        check_reset_values("rst_release");
        base = sends_seen;
        for (int i = 0; i < FC + 5; i++) step(1'b0, 8'h00);
        check_eq("no_send_after_rst", 32'(sends_seen - base), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries (power of two, 2..256).
REQ-002 Parameter FRAME_CYCLES, default 57292, minimum clocks between successive send_data pulses (11 bit times at 9600 baud, 50 MHz).
REQ-003 clk  input  1  system clock (MAX10_CLK1_50 domain); all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  push request, one byte per cycle while high.
REQ-006 wr_data  input  8  byte to push.
REQ-007 tx_data  output  8  byte presented to TX data_in.
REQ-008 send_data  output  1  one-cycle start pulse to TX send_data.
REQ-009 busy  output  1  high when FIFO non-empty or a frame is in progress.
REQ-010 count  output  clog2(DEPTH)+1  current occupancy.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 overflow  output  1  one-cycle pulse on a dropped push.

Function
REQ-014 Storage: DEPTH x 8 array, read/write pointers wrap modulo DEPTH.
REQ-015 Push: wr_en && !full at the edge writes wr_data at wr_ptr, advances wr_ptr.
REQ-016 Push while full: data dropped, pointers and count unchanged, overflow high the next cycle only.
REQ-017 full/empty are registered-state decodes of count; a same-cycle pop never admits a push when full.
REQ-018 Simultaneous accepted push and pop: count unchanged, both pointers advance.
REQ-019 FSM states: IDLE, SEND, WAIT.
REQ-020 IDLE: if !empty, tx_data <= mem[rd_ptr], rd_ptr++, count--, go SEND; else stay.
REQ-021 SEND: send_data = 1 for exactly this cycle, tx_data stable, clear frame counter, go WAIT.
REQ-022 WAIT: frame counter increments each cycle; at FRAME_CYCLES-1 go IDLE.
REQ-023 send_data pulse spacing for back-to-back bytes = FRAME_CYCLES + 2 cycles (SEND + WAIT + IDLE).
REQ-024 Latency: push accepted at edge N into empty idle FIFO -> tx_data loaded at edge N+1, send_data high in the cycle after edge N+1 (sampled at edge N+2).
REQ-025 tx_data holds last popped byte until the next IDLE->SEND load.
REQ-026 busy = !empty || state != IDLE, combinational from registers.
REQ-027 Pushes accepted in any FSM state; FSM never stalls push path.
REQ-028 Frame counter width clog2(FRAME_CYCLES); no wrap before terminal count.
REQ-029 Bytes leave in strict push order; no byte duplicated or skipped except REQ-016 drops.

Reset
REQ-030 rst high: state IDLE, pointers 0, count 0, frame counter 0, tx_data 8'h00, send_data 0, overflow 0, empty 1, full 0, busy 0, immediately (asynchronously).
REQ-031 Reset mid-frame (SEND or WAIT) discards queued bytes and the in-progress frame timer; no send_data pulse for 1 cycle after release.
REQ-032 Memory contents need not be cleared; unreachable through count/pointers.

Verification
REQ-033 Single byte: push 8'hA5 into empty idle FIFO -> tx_data = 8'hA5, one send_data pulse 2 cycles after push edge, busy low after FRAME_CYCLES+2 cycles.
REQ-034 Burst: push 8'h01..8'h04 on consecutive cycles -> send_data pulses carry 01,02,03,04 in order, spaced FRAME_CYCLES+2 cycles, count peaks at 3.
REQ-035 Overflow: with FRAME_CYCLES large, push DEPTH+2 bytes -> full high, exactly 2 overflow pulses (after last dropped push, one per drop), the DEPTH bytes after the first popped are not corrupted.
REQ-036 Pointer wrap: push/drain 3*DEPTH bytes of incrementing values -> output sequence matches exactly.
REQ-037 Simultaneous push/pop: push on the IDLE->SEND pop edge with count=1 -> count stays 1, ordering preserved.
REQ-038 Reset in WAIT with 3 bytes queued -> all outputs at REQ-030 values asynchronously, no send_data after release until new push.
